// File: rtl/i2c_codec_target.sv
// I2C write-only register target for an audio codec style control port.
// Define I2C_CODEC_TARGET_GLITCH_FILTER_EN to add a 3-sample line filter.
module i2c_codec_target #(
    parameter logic [6:0] DEV_ADDR    = 7'h1A,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       KEY,
    input  logic       FPGA_I2C_SCLK,
    inout  wire        FPGA_I2C_SDAT,
    output logic       wr_valid,
    output logic [6:0] wr_addr,
    output logic [8:0] wr_data,
    input  logic [3:0] rd_addr,
    output logic [8:0] rd_data,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ACK_A, BYTE1, ACK_1, BYTE2, ACK_2, IGNORE
    } state_t;

    localparam logic [7:0] ADDR_W = {DEV_ADDR, 1'b0};

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_s;
    logic                   sda_s;
    logic                   scl_f;
    logic                   sda_f;
    logic                   scl_q;
    logic                   sda_q;
    logic                   sda_oe;
    state_t                 state;
    logic [2:0]             bit_cnt;
    logic [6:0]             shreg;
    logic [7:0]             byte1;
    logic [8:0]             regfile [16];

    assign FPGA_I2C_SDAT = (sda_oe && !KEY) ? 1'b0 : 1'bz;

    always_ff @(posedge clk or posedge KEY) begin
        if (KEY) begin
            scl_sync <= '1;
            sda_sync <= '1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], FPGA_I2C_SCLK};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], FPGA_I2C_SDAT};
        end
    end

    assign scl_s = scl_sync[SYNC_STAGES-1];
    assign sda_s = sda_sync[SYNC_STAGES-1];

`ifdef I2C_CODEC_TARGET_GLITCH_FILTER_EN
    // A line only moves once three consecutive samples agree.
    logic [1:0] scl_h;
    logic [1:0] sda_h;
    logic       scl_fq;
    logic       sda_fq;

    assign scl_f = (scl_s == scl_h[0] && scl_s == scl_h[1]) ? scl_s : scl_fq;
    assign sda_f = (sda_s == sda_h[0] && sda_s == sda_h[1]) ? sda_s : sda_fq;

    always_ff @(posedge clk or posedge KEY) begin
        if (KEY) begin
            scl_h  <= '1;
            sda_h  <= '1;
            scl_fq <= 1'b1;
            sda_fq <= 1'b1;
        end else begin
            scl_h  <= {scl_h[0], scl_s};
            sda_h  <= {sda_h[0], sda_s};
            scl_fq <= scl_f;
            sda_fq <= sda_f;
        end
    end
`else
    assign scl_f = scl_s;
    assign sda_f = sda_s;
`endif

    always_ff @(posedge clk or posedge KEY) begin
        if (KEY) begin
            scl_q <= 1'b1;
            sda_q <= 1'b1;
        end else begin
            scl_q <= scl_f;
            sda_q <= sda_f;
        end
    end

    logic       scl_rise;
    logic       scl_fall;
    logic       start_det;
    logic       stop_det;
    logic [7:0] next_byte;
    logic       commit;
    logic [6:0] c_addr;
    logic [8:0] c_data;

    assign scl_rise  = scl_f && !scl_q;
    assign scl_fall  = !scl_f && scl_q;
    assign start_det = scl_f && scl_q && sda_q && !sda_f;
    assign stop_det  = scl_f && scl_q && !sda_q && sda_f;
    assign next_byte = {shreg, sda_f};
    assign commit    = (state == BYTE2) && scl_rise && (bit_cnt == 3'd7);
    assign c_addr    = byte1[7:1];
    assign c_data    = {byte1[0], next_byte};

    always_ff @(posedge clk or posedge KEY) begin
        if (KEY) begin
            state    <= IDLE;
            bit_cnt  <= 3'd0;
            shreg    <= 7'd0;
            byte1    <= 8'd0;
            sda_oe   <= 1'b0;
            busy     <= 1'b0;
            wr_valid <= 1'b0;
            wr_addr  <= 7'd0;
            wr_data  <= 9'd0;
        end else begin
            wr_valid <= commit;
            if (commit) begin
                wr_addr <= c_addr;
                wr_data <= c_data;
            end
            if (start_det) begin
                state   <= ADDR;
                bit_cnt <= 3'd0;
                sda_oe  <= 1'b0;
                busy    <= 1'b1;
            end else if (stop_det) begin
                state   <= IDLE;
                bit_cnt <= 3'd0;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    ADDR, BYTE1, BYTE2: begin
                        if (scl_rise) begin
                            shreg   <= next_byte[6:0];
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                case (state)
                                    ADDR:
                                        state <= (next_byte == ADDR_W) ? ACK_A : IGNORE;
                                    BYTE1: begin
                                        byte1 <= next_byte;
                                        state <= ACK_1;
                                    end
                                    default: state <= ACK_2;
                                endcase
                            end
                        end
                    end
                    ACK_A, ACK_1, ACK_2: begin
                        // First falling edge opens the ACK window, the next closes it.
                        if (scl_fall) begin
                            if (!sda_oe) begin
                                sda_oe <= 1'b1;
                            end else begin
                                sda_oe <= 1'b0;
                                case (state)
                                    ACK_A:   state <= BYTE1;
                                    ACK_1:   state <= BYTE2;
                                    default: state <= IGNORE;
                                endcase
                            end
                        end
                    end
                    default: sda_oe <= 1'b0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge KEY) begin
        if (KEY) begin
            for (int i = 0; i < 16; i++) regfile[i] <= 9'd0;
        end else if (commit) begin
            if (c_addr == 7'd15) begin
                for (int i = 0; i < 16; i++) regfile[i] <= 9'd0;
            end else if (c_addr < 7'd15) begin
                regfile[c_addr[3:0]] <= c_data;
            end
        end
    end

    assign rd_data = regfile[rd_addr];

endmodule

// File: doc/i2c_codec_target.md
I2C_CODEC_TARGET -- requirements
Module: i2c_codec_target

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h1A, the 7-bit target address (address byte 0x34 for write).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, the number of synchronizer flops on SCL and SDA (minimum 2).
REQ-003 SHALL have port clk, input, 1 bit: system clock, at least 8x the SCL rate.
REQ-004 SHALL have port KEY, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port FPGA_I2C_SCLK, input, 1 bit: bus clock from the initiator.
REQ-006 SHALL have port FPGA_I2C_SDAT, inout, 1 bit: bus data; the block drives only 0 or Z.
REQ-007 SHALL have port wr_valid, output, 1 bit: one-cycle pulse when a register write is committed.
REQ-008 SHALL have port wr_addr, output, 7 bits: register address of the last committed write.
REQ-009 SHALL have port wr_data, output, 9 bits: data of the last committed write.
REQ-010 SHALL have port rd_addr, input, 4 bits: register-file read index.
REQ-011 SHALL have port rd_data, output, 9 bits: combinational register-file contents at rd_addr.
REQ-012 SHALL have port busy, output, 1 bit: high from START detect to STOP detect.

Function
REQ-013 SHALL synchronize SCL and SDA through SYNC_STAGES flops; all edge and condition detection uses the synchronized values.
REQ-014 SHALL detect START as SDA falling while SCL is high, and STOP as SDA rising while SCL is high.
REQ-015 SHALL implement the states IDLE, ADDR, ACK_A, BYTE1, ACK_1, BYTE2, ACK_2, IGNORE.
REQ-016 SHALL sample data bits MSB-first on synchronized SCL rising edges, using a 3-bit bit counter that wraps 7->0 per byte.
REQ-017 SHALL move from ADDR to ACK_A when the address byte equals {DEV_ADDR,0}; on an address mismatch or R/W=1 it SHALL not ACK and SHALL go to IGNORE.
REQ-018 SHALL, in each ACK state, pull SDA low from the SCL falling edge after the 8th bit until the next SCL falling edge, then release it.
REQ-019 SHALL decode BYTE1 as {reg_addr[6:0], data[8]} and BYTE2 as data[7:0].
REQ-020 SHALL, on the 8th SCL rise of BYTE2, pulse wr_valid for exactly 1 clk and update wr_addr and wr_data in the same cycle.
REQ-021 SHALL store the write into regfile[reg_addr] when reg_addr<=14; for reg_addr>15 it SHALL ACK and pulse wr_valid but not store.
REQ-022 SHALL, on a write to reg_addr 15 (reset register), clear all 16 regfile entries to 0 in the commit cycle.
REQ-023 SHALL leave ACK_2 for IGNORE; any further byte SHALL be NACKed (SDA released).
REQ-024 SHALL, on a STOP detected in any state, go to IDLE and discard any partial transfer without a commit.
REQ-025 SHALL, on a repeated START detected in any state, go to ADDR with the bit counter cleared.
REQ-026 SHALL never drive SDA outside the ACK windows; IGNORE and IDLE leave SDA at Z.

Reset
REQ-027 SHALL, while KEY=1, force: state=IDLE, SDA=Z, wr_valid=0, wr_addr=0, wr_data=0, busy=0, regfile all 0, synchronizers to 1.
REQ-028 SHALL, when KEY is asserted mid-transfer, release SDA immediately (asynchronously), and the first event after deassert SHALL be a fresh START.

Configuration
REQ-029 SHALL, when macro I2C_CODEC_TARGET_GLITCH_FILTER_EN is defined, follow the synchronizers with a 3-sample stability filter per line, so an output changes only after 3 equal consecutive samples (+2 cycles latency; pulses <=2 clk are rejected).
REQ-030 SHALL, when I2C_CODEC_TARGET_GLITCH_FILTER_EN is undefined, use the synchronizer outputs directly, with no filter logic.

Verification
REQ-031 Bench: START, 0x34, 0x0E, 0x5A, STOP -> three ACKs, wr_valid pulses once, wr_addr=0x07, wr_data=0x05A, rd_addr=7 gives 0x05A.
REQ-032 Bench: preload registers, then START, 0x34, 0x1E, 0x00, STOP -> ACKs, wr_addr=0x0F, all rd_data=0.
REQ-033 Bench: START, 0x36, ... and START, 0x35, ... -> SDA never low in the 9th clock, no wr_valid, busy until STOP.
REQ-034 Bench: START, 0x34, 0x0E, STOP -> no wr_valid, regfile unchanged, state IDLE.
REQ-035 Bench: KEY pulsed during BYTE1 ACK -> SDA released within 1 clk, outputs at reset values, next full write commits normally.
REQ-036 Bench: 1-clk SCL glitch during BYTE2 -> with the macro, write commits correctly; without it, a bit shift is observed.
